mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one downstream memory slave port among NUM_REQ warp-level requesters (e.g. per-scheduler LSU front-ends).
- Signal set per port matches the team's memory interface: warp_id, thread_mask, per-thread address/write_data/read_data, write_en, request_valid/ready/response_valid.
- Round-robin grant with a registered issue stage; an in-order owner FIFO routes each downstream response back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- THREADS_PER_WARP, 32, lanes per request.
- MAX_OUTSTANDING, 8, owner-FIFO depth (power of 2) = max accepted-but-unanswered requests.

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  [NUM_REQ]  requester i presents a request.
- req_warp_id  input  [NUM_REQ][6]  warp id.
- req_thread_mask  input  [NUM_REQ][32]  active lanes.
- req_write_en  input  [NUM_REQ]  1 = store, 0 = load.
- req_address  input  [NUM_REQ][THREADS_PER_WARP][32]  per-lane address.
- req_write_data  input  [NUM_REQ][THREADS_PER_WARP][32]  per-lane store data.
- req_ready  output  [NUM_REQ]  one-hot pulse: request i accepted this cycle.
- rsp_valid  output  [NUM_REQ]  one-hot: response for requester i.
- rsp_read_data  output  [THREADS_PER_WARP][32]  response data, shared by all requesters.
- mem_request_valid  output  1  downstream request valid.
- mem_warp_id, mem_thread_mask, mem_write_en, mem_address, mem_write_data  output  widths as req_*  registered downstream request.
- mem_ready  input  1  downstream accepts when high with mem_request_valid.
- mem_response_valid  input  1  downstream response (one per accepted request, loads and stores).
- mem_read_data  input  [THREADS_PER_WARP][32]  downstream response data.
- err_orphan_rsp  output  1  sticky: response arrived with owner FIFO empty.

Behaviour:
- Reset (async assert, sync deassert via rst_n): all outputs 0, FSM=IDLE, rr_ptr=0, FIFO empty, err_orphan_rsp=0.
- FSM IDLE:
  - If any req_valid and FIFO not full: pick the first valid index at or after rr_ptr (wrapping mod NUM_REQ).
  - Capture that requester's fields into mem_* registers; assert req_ready[g] for this cycle only; go to ISSUE.
  - rr_ptr <= (g+1) mod NUM_REQ.
- FSM ISSUE: mem_request_valid=1; fields held stable until mem_ready.
  - On mem_ready: push g into owner FIFO; deassert mem_request_valid next cycle; return to IDLE.
  - Back-to-back issue: the cycle mem_ready is seen, a new grant may be made in the same cycle (ISSUE->ISSUE) if a requester is valid and FIFO count after push < MAX_OUTSTANDING.
  - Minimum issue latency is 1 cycle (req_valid at N -> mem_request_valid at N+1).
- Requester contract: fields stable while req_valid && !req_ready[i]. The arbiter samples fields only in the grant cycle.
- Full: FIFO count == MAX_OUTSTANDING blocks new grants; pending requesters wait, and rr_ptr is unchanged.
- Response path: on mem_response_valid, pop the FIFO head h.
  - Next cycle: rsp_valid[h]=1 and rsp_read_data=mem_read_data (registered, 1-cycle latency). Stores also produce rsp_valid.
- Simultaneous push and pop in the same cycle: count unchanged; legal at full and at empty (push-then-pop is not required; pop on empty is an orphan).
- Orphan: mem_response_valid with FIFO empty and no same-cycle push -> no rsp_valid; err_orphan_rsp=1 until reset.
- Reset mid-operation: in-flight request and FIFO discarded; downstream must also be reset.
- Count width is clog2(MAX_OUTSTANDING)+1. Pointers wrap naturally.

Decomposition:
- Shared package gpu_mem_pkg:
  - WARP_ID_W=6, ADDR_W=32, DATA_W=32;
  - typedef mem_req_t {warp_id, thread_mask, write_en, address[], write_data[]};
  - typedef arb_state_e {IDLE, ISSUE}.
- One sub-module: mem_owner_fifo (sync FIFO of clog2(NUM_REQ)-bit ids with push/pop/full/empty/count).
- Round-robin pick stays inline.

Test Plan:
- Single request: req_valid[2]=1, warp 5, mask 0xFFFF_FFFF, load, mem_ready=1 -> req_ready=4'b0100 at N, mem_request_valid at N+1 with warp_id 5; response 3 cycles later -> rsp_valid=4'b0100 one cycle after mem_response_valid, data echoed.
- Fairness: all 4 req_valid held high, mem_ready=1 always -> grant order 0,1,2,3,0,1,...; no requester granted twice before the others.
- Backpressure: mem_ready=0 for 5 cycles -> mem_* fields and mem_request_valid stable, no further req_ready pulses; accept on cycle 6.
- Full: MAX_OUTSTANDING=8, no responses, continuous requests -> exactly 8 accepts, then req_ready stays 0. One mem_response_valid -> one more grant next cycle.
- Routing: issue from 3,0,1 (with stores); responses return in order -> rsp_valid 4'b1000, 4'b0001, 4'b0010 respectively.
- Orphan/reset: mem_response_valid with nothing outstanding -> err_orphan_rsp=1, no rsp_valid. Assert rst_n=0 mid-ISSUE -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and widths for the GPU warp-level memory interface.
package gpu_mem_pkg;

   localparam int WARP_ID_W   = 6;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int DEF_THREADS = 32;

   typedef logic [WARP_ID_W-1:0] warp_id_t;
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [DATA_W-1:0]    data_t;

   // One full warp request at the default warp width.
   typedef struct packed {
      warp_id_t                   warp_id;
      logic [DEF_THREADS-1:0]     thread_mask;
      logic                       write_en;
      addr_t [DEF_THREADS-1:0]    address;
      data_t [DEF_THREADS-1:0]    write_data;
   } mem_req_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_owner_fifo.sv
// In-order FIFO of requester ids; records who owns each outstanding request.
// A pop on an empty FIFO that coincides with a push consumes the pushed id
// directly, so a response in the same cycle as its request still routes.
module mem_owner_fifo #(
   parameter int DEPTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [ID_W-1:0]            push_id,
   input  logic                       pop,
   output logic [ID_W-1:0]            pop_id,
   output logic                       pop_hit,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ID_W-1:0]  slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             bypass;
   logic             wr_en;
   logic             rd_en;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign bypass  = push && pop && empty;
   assign wr_en   = push && !bypass && (!full || pop);
   assign rd_en   = pop && !empty;
   assign pop_id  = empty ? push_id : slots[rd_ptr];
   assign pop_hit = pop && (!empty || push);

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         slots[wr_ptr] <= push_id;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among warp-level
// requesters. A registered issue stage holds the granted request until the
// slave accepts it; an owner FIFO routes in-order responses back.
module mem_req_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int THREADS_PER_WARP = 32,
   parameter int MAX_OUTSTANDING  = 8
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic [NUM_REQ-1:0]                                  req_valid,
   input  logic [NUM_REQ-1:0][WARP_ID_W-1:0]                   req_warp_id,
   input  logic [NUM_REQ-1:0][THREADS_PER_WARP-1:0]            req_thread_mask,
   input  logic [NUM_REQ-1:0]                                  req_write_en,
   input  logic [NUM_REQ-1:0][THREADS_PER_WARP-1:0][ADDR_W-1:0] req_address,
   input  logic [NUM_REQ-1:0][THREADS_PER_WARP-1:0][DATA_W-1:0] req_write_data,
   output logic [NUM_REQ-1:0]                                  req_ready,
   output logic [NUM_REQ-1:0]                                  rsp_valid,
   output logic [THREADS_PER_WARP-1:0][DATA_W-1:0]             rsp_read_data,
   output logic                                                mem_request_valid,
   output logic [WARP_ID_W-1:0]                                mem_warp_id,
   output logic [THREADS_PER_WARP-1:0]                         mem_thread_mask,
   output logic                                                mem_write_en,
   output logic [THREADS_PER_WARP-1:0][ADDR_W-1:0]             mem_address,
   output logic [THREADS_PER_WARP-1:0][DATA_W-1:0]             mem_write_data,
   input  logic                                                mem_ready,
   input  logic                                                mem_response_valid,
   input  logic [THREADS_PER_WARP-1:0][DATA_W-1:0]             mem_read_data,
   output logic                                                err_orphan_rsp
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   arb_state_e       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] mem_owner;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand;
   logic             pick_found;
   logic             room;
   logic             grant;
   logic             push;
   logic [IDX_W-1:0] pop_id;
   logic             pop_hit;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Find the first valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // A grant needs an owner slot: from IDLE the FIFO must not be full, and
   // on a back-to-back issue there must still be room after this cycle's push.
   always_comb begin
      room = 1'b0;
      if (state == IDLE) begin
         room = !fifo_full;
      end else begin
         room = mem_ready && ((int'(fifo_count) + 1) < MAX_OUTSTANDING);
      end
      grant     = rst_n && pick_found && room;
      req_ready = grant ? (NUM_REQ'(1) << pick_idx) : '0;
   end

   assign push = (state == ISSUE) && mem_ready;

   mem_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .ID_W  (IDX_W)
   ) u_owner_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .push_id (mem_owner),
      .pop     (mem_response_valid),
      .pop_id  (pop_id),
      .pop_hit (pop_hit),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Issue FSM: capture the granted request and hold it until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         mem_owner         <= '0;
         mem_request_valid <= 1'b0;
         mem_warp_id       <= '0;
         mem_thread_mask   <= '0;
         mem_write_en      <= 1'b0;
         mem_address       <= '0;
         mem_write_data    <= '0;
      end else begin
         if (grant) begin
            mem_owner       <= pick_idx;
            mem_warp_id     <= req_warp_id[pick_idx];
            mem_thread_mask <= req_thread_mask[pick_idx];
            mem_write_en    <= req_write_en[pick_idx];
            mem_address     <= req_address[pick_idx];
            mem_write_data  <= req_write_data[pick_idx];
            rr_ptr          <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
         end
         case (state)
            IDLE: begin
               if (grant) begin
                  state             <= ISSUE;
                  mem_request_valid <= 1'b1;
               end
            end
            ISSUE: begin
               if (mem_ready && !grant) begin
                  state             <= IDLE;
                  mem_request_valid <= 1'b0;
               end
            end
            default: begin
               state             <= IDLE;
               mem_request_valid <= 1'b0;
            end
         endcase
      end
   end

   // Route each response to its owner one cycle later; flag orphans sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid      <= '0;
         rsp_read_data  <= '0;
         err_orphan_rsp <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (mem_response_valid && pop_hit) begin
            rsp_valid     <= NUM_REQ'(1) << pop_id;
            rsp_read_data <= mem_read_data;
         end
         if (mem_response_valid && !pop_hit) begin
            err_orphan_rsp <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter: grant order, backpressure, owner
// FIFO full/routing, orphan responses and asynchronous reset.
module tb_mem_req_arbiter;

   localparam int NR  = 4;
   localparam int TPW = 32;
   localparam int MO  = 8;

   logic                               clk;
   logic                               rst_n;
   logic [NR-1:0]                      req_valid;
   logic [NR-1:0][5:0]                 req_warp_id;
   logic [NR-1:0][TPW-1:0]             req_thread_mask;
   logic [NR-1:0]                      req_write_en;
   logic [NR-1:0][TPW-1:0][31:0]       req_address;
   logic [NR-1:0][TPW-1:0][31:0]       req_write_data;
   logic [NR-1:0]                      req_ready;
   logic [NR-1:0]                      rsp_valid;
   logic [TPW-1:0][31:0]               rsp_read_data;
   logic                               mem_request_valid;
   logic [5:0]                         mem_warp_id;
   logic [TPW-1:0]                     mem_thread_mask;
   logic                               mem_write_en;
   logic [TPW-1:0][31:0]               mem_address;
   logic [TPW-1:0][31:0]               mem_write_data;
   logic                               mem_ready;
   logic                               mem_response_valid;
   logic [TPW-1:0][31:0]               mem_read_data;
   logic                               err_orphan_rsp;

   int checks;
   int errors;
   int accepts;

   mem_req_arbiter #(
      .NUM_REQ          (NR),
      .THREADS_PER_WARP (TPW),
      .MAX_OUTSTANDING  (MO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_warp_id        (req_warp_id),
      .req_thread_mask    (req_thread_mask),
      .req_write_en       (req_write_en),
      .req_address        (req_address),
      .req_write_data     (req_write_data),
      .req_ready          (req_ready),
      .rsp_valid          (rsp_valid),
      .rsp_read_data      (rsp_read_data),
      .mem_request_valid  (mem_request_valid),
      .mem_warp_id        (mem_warp_id),
      .mem_thread_mask    (mem_thread_mask),
      .mem_write_en       (mem_write_en),
      .mem_address        (mem_address),
      .mem_write_data     (mem_write_data),
      .mem_ready          (mem_ready),
      .mem_response_valid (mem_response_valid),
      .mem_read_data      (mem_read_data),
      .err_orphan_rsp     (err_orphan_rsp)
   );

   // Free-running clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] addrOf(input int i, input int l);
      return 32'h1000_0000 + 32'(i) * 32'h1_0000 + 32'(l) * 32'd4;
   endfunction

   function automatic logic [31:0] wdataOf(input int i, input int l);
      return 32'hD000_0000 + 32'(i) * 32'h100 + 32'(l);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic setReq(input int i, input logic [5:0] warp, input logic [31:0] mask, input logic we);
      req_warp_id[i]     = warp;
      req_thread_mask[i] = mask;
      req_write_en[i]    = we;
      for (int l = 0; l < TPW; l++) begin
         req_address[i][l]    = addrOf(i, l);
         req_write_data[i][l] = wdataOf(i, l);
      end
   endtask

   // Advance to the middle of the next cycle, drive inputs, let them settle.
   task automatic applyStimulus(input logic [NR-1:0] valid, input logic mready,
                                input logic rspv, input logic [31:0] seed);
      @(negedge clk);
      req_valid          = valid;
      mem_ready          = mready;
      mem_response_valid = rspv;
      for (int l = 0; l < TPW; l++) begin
         mem_read_data[l] = seed + 32'(l);
      end
      #1;
   endtask

   task automatic drainResponses(input string tag, input int n, input int order[8], input logic [31:0] base);
      for (int k = 0; k <= n; k++) begin
         applyStimulus(4'b0000, 1'b0, (k < n), base + 32'(k) * 32'h100);
         if (k > 0) begin
            checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1 << order[k-1]);
            checkOutput({tag, "_rsp_data"}, 64'(rsp_read_data[7]), 64'(base + 32'(k - 1) * 32'h100 + 32'd7));
         end
      end
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput({tag, "_rsp_idle"}, 64'(rsp_valid), 64'd0);
   endtask

   // Directed sequence of test steps.
   initial begin
      int order2[8];
      int order3[8];
      int order4[8];
      int order5[8];
      checks             = 0;
      errors             = 0;
      accepts            = 0;
      rst_n              = 1'b0;
      req_valid          = '0;
      mem_ready          = 1'b0;
      mem_response_valid = 1'b0;
      mem_read_data      = '0;
      for (int i = 0; i < NR; i++) begin
         setReq(i, 6'(10 + i), 32'hFFFF_FFFF, 1'b0);
      end

      // Reset state
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset_mem_valid", 64'(mem_request_valid), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_err", 64'(err_orphan_rsp), 64'd0);
      checkOutput("reset_warp", 64'(mem_warp_id), 64'd0);
      applyStimulus(4'b1111, 1'b1, 1'b0, 32'h0);
      checkOutput("reset_no_grant", 64'(req_ready), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;

      // Single load from requester 2
      setReq(2, 6'd5, 32'hFFFF_FFFF, 1'b0);
      applyStimulus(4'b0100, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_grant", 64'(req_ready), 64'h4);
      checkOutput("t1_latency", 64'(mem_request_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_mem_valid", 64'(mem_request_valid), 64'd1);
      checkOutput("t1_warp", 64'(mem_warp_id), 64'd5);
      checkOutput("t1_mask", 64'(mem_thread_mask), 64'hFFFF_FFFF);
      checkOutput("t1_we", 64'(mem_write_en), 64'd0);
      checkOutput("t1_addr3", 64'(mem_address[3]), 64'(addrOf(2, 3)));
      checkOutput("t1_wdata31", 64'(mem_write_data[31]), 64'(wdataOf(2, 31)));
      checkOutput("t1_no_regrant", 64'(req_ready), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_mem_drop", 64'(mem_request_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 32'hA100_0000);
      checkOutput("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h4);
      checkOutput("t1_rsp_data0", 64'(rsp_read_data[0]), 64'hA100_0000);
      checkOutput("t1_rsp_data31", 64'(rsp_read_data[31]), 64'hA100_001F);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
      setReq(2, 6'd12, 32'hFFFF_FFFF, 1'b0);

      // Fairness: pointer sits at 3 after the single grant to 2
      order2 = '{3, 0, 1, 2, 3, 0, 0, 0};
      for (int k = 0; k < 6; k++) begin
         applyStimulus(4'b1111, 1'b1, 1'b0, 32'h0);
         checkOutput("t2_grant", 64'(req_ready), 64'd1 << order2[k]);
         if (k > 0) begin
            checkOutput("t2_warp", 64'(mem_warp_id), 64'(10 + order2[k-1]));
         end
      end
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t2_last_valid", 64'(mem_request_valid), 64'd1);
      checkOutput("t2_last_warp", 64'(mem_warp_id), 64'd10);
      checkOutput("t2_no_grant", 64'(req_ready), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t2_idle", 64'(mem_request_valid), 64'd0);
      drainResponses("t2", 6, order2, 32'hB000_0000);

      // Backpressure: grant 1, hold for 5 cycles with requester 0 waiting
      applyStimulus(4'b0010, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_grant1", 64'(req_ready), 64'h2);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0001, 1'b0, 1'b0, 32'h0);
         checkOutput("t3_hold_ready", 64'(req_ready), 64'd0);
         checkOutput("t3_hold_valid", 64'(mem_request_valid), 64'd1);
         checkOutput("t3_hold_warp", 64'(mem_warp_id), 64'd11);
         checkOutput("t3_hold_addr", 64'(mem_address[0]), 64'(addrOf(1, 0)));
      end
      applyStimulus(4'b0001, 1'b1, 1'b0, 32'h0);
      checkOutput("t3_b2b_grant", 64'(req_ready), 64'h1);
      checkOutput("t3_accept_warp", 64'(mem_warp_id), 64'd11);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_next_valid", 64'(mem_request_valid), 64'd1);
      checkOutput("t3_next_warp", 64'(mem_warp_id), 64'd10);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("t3_idle", 64'(mem_request_valid), 64'd0);
      order3 = '{1, 0, 0, 0, 0, 0, 0, 0};
      drainResponses("t3", 2, order3, 32'hB100_0000);

      // Full: continuous requests with no responses
      for (int k = 0; k < 12; k++) begin
         applyStimulus(4'b1111, 1'b1, 1'b0, 32'h0);
         accepts += $countones(req_ready);
      end
      checkOutput("t4_accepts", 64'(accepts), 64'd8);
      checkOutput("t4_full_ready", 64'(req_ready), 64'd0);
      checkOutput("t4_full_valid", 64'(mem_request_valid), 64'd0);
      applyStimulus(4'b1111, 1'b1, 1'b1, 32'hC000_0000);
      checkOutput("t4_pop_cycle_ready", 64'(req_ready), 64'd0);
      checkOutput("t4_pop_cycle_rsp", 64'(rsp_valid), 64'd0);
      applyStimulus(4'b1111, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_regrant", 64'(req_ready), 64'h2);
      checkOutput("t4_rsp", 64'(rsp_valid), 64'h2);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_refull_ready", 64'(req_ready), 64'd0);
      order4 = '{2, 3, 0, 1, 2, 3, 0, 1};
      drainResponses("t4", 8, order4, 32'hC100_0000);

      // Routing with stores: issue 3, 0, 1
      setReq(3, 6'd13, 32'h0000_FFFF, 1'b1);
      setReq(0, 6'd10, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(4'b1000, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_grant3", 64'(req_ready), 64'h8);
      applyStimulus(4'b0001, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_grant0", 64'(req_ready), 64'h1);
      checkOutput("t5_warp3", 64'(mem_warp_id), 64'd13);
      checkOutput("t5_mask3", 64'(mem_thread_mask), 64'h0000_FFFF);
      checkOutput("t5_we3", 64'(mem_write_en), 64'd1);
      checkOutput("t5_wdata3", 64'(mem_write_data[5]), 64'(wdataOf(3, 5)));
      applyStimulus(4'b0010, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_grant1", 64'(req_ready), 64'h2);
      checkOutput("t5_warp0", 64'(mem_warp_id), 64'd10);
      checkOutput("t5_we0", 64'(mem_write_en), 64'd1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_warp1", 64'(mem_warp_id), 64'd11);
      checkOutput("t5_we1", 64'(mem_write_en), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("t5_idle", 64'(mem_request_valid), 64'd0);
      order5 = '{3, 0, 1, 0, 0, 0, 0, 0};
      drainResponses("t5", 3, order5, 32'hD100_0000);

      // Orphan response with nothing outstanding
      applyStimulus(4'b0000, 1'b0, 1'b1, 32'hE000_0000);
      checkOutput("t6_err_before", 64'(err_orphan_rsp), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("t6_err_set", 64'(err_orphan_rsp), 64'd1);
      checkOutput("t6_no_rsp", 64'(rsp_valid), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      checkOutput("t6_err_sticky", 64'(err_orphan_rsp), 64'd1);

      // Asynchronous reset in the middle of an issue
      applyStimulus(4'b0100, 1'b0, 1'b0, 32'h0);
      checkOutput("t7_grant2", 64'(req_ready), 64'h4);
      applyStimulus(4'b1111, 1'b0, 1'b0, 32'h0);
      checkOutput("t7_issuing", 64'(mem_request_valid), 64'd1);
      checkOutput("t7_stalled", 64'(req_ready), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t7_rst_valid", 64'(mem_request_valid), 64'd0);
      checkOutput("t7_rst_warp", 64'(mem_warp_id), 64'd0);
      checkOutput("t7_rst_err", 64'(err_orphan_rsp), 64'd0);
      checkOutput("t7_rst_ready", 64'(req_ready), 64'd0);
      checkOutput("t7_rst_rsp", 64'(rsp_valid), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
